// File: rtl/apb_pkg.sv
// Shared APB completer types and default widths for the parametrised APB memories.
package apb_pkg;

  localparam int unsigned APB_ADDR_WIDTH_DEF = 10;
  localparam int unsigned APB_DATA_WIDTH_DEF = 32;
  localparam int unsigned APB_DEPTH_DEF      = 256;
  localparam int unsigned APB_WAIT_CNT_W     = 4;

  typedef enum logic [1:0] {
    CPL_IDLE = 2'd0,
    CPL_WAIT = 2'd1,
    CPL_RESP = 2'd2
  } apb_cpl_state_t;

  typedef enum logic {
    OKAY   = 1'b0,
    SLVERR = 1'b1
  } apb_resp_t;

endpackage

// File: rtl/dpmem_ram.sv
// True dual-port byte-enable RAM, read-first on both ports.
// When both ports write the same word at one edge, port A owns the bytes both enable.
module dpmem_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned AW         = $clog2(DEPTH),
  parameter int unsigned NB         = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  a_en_i,
  input  logic                  a_we_i,
  input  logic [AW-1:0]         a_addr_i,
  input  logic [NB-1:0]         a_be_i,
  input  logic [DATA_WIDTH-1:0] a_wdata_i,
  output logic [DATA_WIDTH-1:0] a_rdata_o,
  input  logic                  b_en_i,
  input  logic                  b_we_i,
  input  logic [AW-1:0]         b_addr_i,
  input  logic [NB-1:0]         b_be_i,
  input  logic [DATA_WIDTH-1:0] b_wdata_i,
  output logic [DATA_WIDTH-1:0] b_rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] a_rdata_q, b_rdata_q;
  logic [NB-1:0]         a_bwe, b_bwe;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    a_bwe = '0;
    b_bwe = '0;
    for (int i = 0; i < int'(NB); i++) begin
      a_bwe[i] = a_en_i & a_we_i & a_be_i[i];
      b_bwe[i] = b_en_i & b_we_i & b_be_i[i] & ~(a_bwe[i] & (a_addr_i == b_addr_i));
    end
  end

  // NOTE: the array has no reset; clearing it would turn the RAM into a huge register file.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(NB); i++) begin
      if (a_bwe[i]) mem_q[a_addr_i][i*8 +: 8] <= a_wdata_i[i*8 +: 8];
      if (b_bwe[i]) mem_q[b_addr_i][i*8 +: 8] <= b_wdata_i[i*8 +: 8];
    end
  end

  // NOTE: non-blocking reads sample the array before this edge's writes land, giving read-first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_en_i) a_rdata_q <= mem_q[a_addr_i];
      if (b_en_i) b_rdata_q <= mem_q[b_addr_i];
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/apb4_dpmem.sv
// APB4 completer in front of a dual-port byte-enable RAM; port B serves a local master.
// Holds the transfer FSM, wait-state counter, request latch and error decode.
module apb4_dpmem
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = APB_ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH  = APB_DATA_WIDTH_DEF,
  parameter int unsigned DEPTH       = APB_DEPTH_DEF,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                       pclk,
  input  logic                       preset,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [ADDR_WIDTH-1:0]      paddr,
  input  logic [DATA_WIDTH-1:0]      pwdata,
  input  logic [DATA_WIDTH/8-1:0]    pstrb,
  input  logic [2:0]                 pprot,
  output logic [DATA_WIDTH-1:0]      prdata,
  output logic                       pready,
  output logic                       pslverr,
  input  logic                       b_en,
  input  logic                       b_we,
  input  logic [$clog2(DEPTH)-1:0]   b_addr,
  input  logic [DATA_WIDTH/8-1:0]    b_be,
  input  logic [DATA_WIDTH-1:0]      b_wdata,
  output logic [DATA_WIDTH-1:0]      b_rdata
);

  localparam int unsigned NB   = DATA_WIDTH / 8;
  localparam int unsigned OFFS = $clog2(NB);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] OFFS_MASK = ADDR_WIDTH'((1 << OFFS) - 1);

  typedef logic [AW-1:0]         word_idx_t;
  typedef logic [NB-1:0]         strb_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  apb_cpl_state_t              state_q, state_d;
  logic [APB_WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  word_idx_t                   addr_q, addr_d;
  logic                        write_q, write_d;
  data_t                       wdata_q, wdata_d;
  strb_t                       strb_q, strb_d;
  apb_resp_t                   resp_q, resp_d;

  logic [ADDR_WIDTH-OFFS-1:0]  req_idx;
  logic                        req_err, setup, commit, ram_a_en;
  word_idx_t                   ram_a_addr;
  data_t                       ram_a_rdata;
  logic                        unused_pprot;

  assign unused_pprot = ^pprot;

  assign req_idx = paddr[ADDR_WIDTH-1:OFFS];
  assign req_err = (32'(req_idx) >= DEPTH) || ((paddr & OFFS_MASK) != '0) || (!pwrite && (pstrb != '0));
  assign setup   = (state_q == CPL_IDLE) && psel && !penable;
  // An aborted response (psel dropped) never writes.
  assign commit  = (state_q == CPL_RESP) && psel && write_q && (resp_q == OKAY);

  assign ram_a_en   = (setup && !req_err) || commit;
  assign ram_a_addr = commit ? addr_q : req_idx[AW-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    resp_d  = resp_q;
    case (state_q)
      CPL_IDLE: begin
        if (psel && !penable) begin
          addr_d  = req_idx[AW-1:0];
          write_d = pwrite;
          wdata_d = pwdata;
          strb_d  = pstrb;
          resp_d  = req_err ? SLVERR : OKAY;
          if (WAIT_STATES == 0) begin
            state_d = CPL_RESP;
          end else begin
            state_d = CPL_WAIT;
            cnt_d   = APB_WAIT_CNT_W'(WAIT_STATES - 1);
          end
        end
      end
      CPL_WAIT: begin
        if (!psel)              state_d = CPL_IDLE;
        else if (cnt_q == '0)   state_d = CPL_RESP;
        else                    cnt_d   = cnt_q - 1'b1;
      end
      CPL_RESP: state_d = CPL_IDLE;
      default:  state_d = CPL_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= CPL_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      resp_q  <= OKAY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      resp_q  <= resp_d;
    end
  end

  assign pready  = (state_q == CPL_RESP);
  assign pslverr = pready && (resp_q == SLVERR);
  assign prdata  = (pready && !write_q && (resp_q == OKAY)) ? ram_a_rdata : '0;

  dpmem_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk_i     (pclk),
    .rst_i     (preset),
    .a_en_i    (ram_a_en),
    .a_we_i    (commit),
    .a_addr_i  (ram_a_addr),
    .a_be_i    (strb_q),
    .a_wdata_i (wdata_q),
    .a_rdata_o (ram_a_rdata),
    .b_en_i    (b_en),
    .b_we_i    (b_we),
    .b_addr_i  (b_addr),
    .b_be_i    (b_be),
    .b_wdata_i (b_wdata),
    .b_rdata_o (b_rdata)
  );

endmodule

// File: doc/apb4_dpmem.md
# apb4_dpmem

APB4 completer fronting a byte-enable dual-port memory, generalising the existing APB memory types to parametrised data/address width and depth. It adds byte strobes, programmable wait states, error responses, and a second native read/write port (port B) for a local master such as a DMA or core. It sits on the APB fabric as one peripheral slot; port B connects directly to local logic.

## Interface

- ADDR_WIDTH, 10, APB byte-address width
- DATA_WIDTH, 32, data width; 8/16/32/64 only
- DEPTH, 256, memory words; must be ≤ 2^(ADDR_WIDTH − OFFS), OFFS = log2(DATA_WIDTH/8)
- WAIT_STATES, 0, extra access-phase cycles before pready (0..15)

- Clock and reset: one clock; reset is synchronous and active-high.
  - pclk  in  1  clock
  - preset  in  1  synchronous active-high reset
- APB side:
  - psel  in  1  select
  - penable  in  1  access phase
  - pwrite  in  1  1 = write
  - paddr  in  ADDR_WIDTH  byte address
  - pwdata  in  DATA_WIDTH  write data
  - pstrb  in  DATA_WIDTH/8  write byte strobes
  - pprot  in  3  ignored
  - prdata  out  DATA_WIDTH  read data
  - pready  out  1  transfer complete
  - pslverr  out  1  error response, valid with pready
- Port B:
  - b_en  in  1  port B access
  - b_we  in  1  port B write
  - b_addr  in  clog2(DEPTH)  word index
  - b_be  in  DATA_WIDTH/8  byte enables
  - b_wdata  in  DATA_WIDTH  write data
  - b_rdata  out  DATA_WIDTH  read data, 1-cycle latency

## Operation

- Reset values:
  - All outputs are 0; FSM state is CPL_IDLE.
  - Memory array is not cleared.
- FSM, states CPL_IDLE / CPL_WAIT / CPL_RESP:
  - CPL_IDLE: at an edge sampling psel=1, penable=0:
    - latch paddr, pwrite, pwdata, pstrb
    - evaluate the error condition
    - issue the memory read
    - go to CPL_RESP if WAIT_STATES=0, else go to CPL_WAIT with cnt=WAIT_STATES−1
  - CPL_WAIT: if cnt=0, go to CPL_RESP; else decrement cnt.
  - CPL_RESP: pready=1 and pslverr valid. At the next edge:
    - commit the write if pwrite and no error
    - return to CPL_IDLE
- Errors (pslverr=1; no write; prdata=0) on any of:
  - word index = paddr[ADDR_WIDTH−1:OFFS] ≥ DEPTH
  - paddr[OFFS−1:0] ≠ 0
  - read with pstrb ≠ 0
- Write with pstrb=0: OKAY response, memory unchanged.
- prdata:
  - holds the addressed word only in CPL_RESP for an OKAY read
  - 0 otherwise
- Abort: psel=0 while not in CPL_IDLE:
  - return to CPL_IDLE at the next edge
  - no write; pready stays 0
- Port B:
  - b_en=1, b_we=0: b_rdata = word at b_addr next cycle
  - b_en=1, b_we=1: write the bytes selected by b_be; b_rdata returns old data (read-first)
  - b_en=0: b_rdata holds its value
- Collisions:
  - Same-edge writes from both ports to the same word: APB wins on bytes enabled by both. Other bytes take their enabling port's data.
  - A read on either port of a word written at the same edge returns the old data.
- preset mid-transfer: FSM goes to CPL_IDLE, outputs go to 0, and the pending write is dropped.

## Timing

- Access-phase length: 1 + WAIT_STATES cycles; pready is registered-state decoded and glitch-free.
- Memory read latency: 1 cycle from the setup-end edge. Data is therefore valid in the first access cycle when WAIT_STATES=0.
- APB write commit: the edge ending the CPL_RESP cycle.
- Back-to-back transfers: a new setup cycle may follow immediately, with no idle cycle required.
- Port B is fully pipelined: one access per cycle.

## Structure

- apb_pkg additions:
  - apb_cpl_state_t {CPL_IDLE, CPL_WAIT, CPL_RESP}
  - apb_resp_t {OKAY=0, SLVERR=1}
  - default width localparams
- Width-dependent types (word index, strobe, data) are local typedefs derived from the parameters.
- One sub-module: dpmem_ram. It is a true dual-port byte-enable RAM, read-first, with APB-priority collision merge.
- Top level holds the FSM, wait counter, decode/error logic and request latch.

## Test plan

- Write/read-back: WAIT_STATES=0, write 0xDEADBEEF to 0x010, pstrb=0xF.
  - pready=1 in the first access cycle, pslverr=0.
  - Read 0x010 returns 0xDEADBEEF.
- Partial strobe: write 0x11223344 to 0x010 with pstrb=0b0101.
  - Read returns 0xDE22BE44.
- Wait states: WAIT_STATES=3, any read.
  - pready low for 3 access cycles, high on the 4th.
  - Aborting (psel=0) during CPL_WAIT returns to CPL_IDLE with no write.
- Errors: DEPTH=192.
  - paddr 0x300 → pslverr=1, prdata=0, memory unchanged.
  - paddr 0x011 → pslverr=1.
  - Read with pstrb=0x1 → pslverr=1.
- Collision: at the same edge, APB write to word 4 with pstrb=0x3, data 0xAAAAAAAA, and port B write to word 4 with be=0xF, data 0x55555555.
  - Word 4 becomes 0x5555AAAA.
  - A concurrent port B read of word 4 returns the prior value.
- Reset: assert preset in CPL_WAIT during a write.
  - Next cycle: pready=0, pslverr=0, prdata=0.
  - Target word unchanged.
